// File: rtl/score_digits_gen_if.sv
// Handshake/display bundle between game logic, score_digits_gen and the 7-segment stage.
interface score_digits_gen_if #(
    parameter int ADD_W = 8
);
    logic             add_req;
    logic [ADD_W-1:0] add_pts;
    logic             score_clr;
    logic             show_hi;
    logic             busy;
    logic             sat;
    logic [4:0]       hex1, hex2, hex3, hex4, hex5, hex6;

    modport master (
        output add_req, add_pts, score_clr, show_hi,
        input  busy, sat, hex1, hex2, hex3, hex4, hex5, hex6
    );
    modport slave (
        input  add_req, add_pts, score_clr, show_hi,
        output busy, sat, hex1, hex2, hex3, hex4, hex5, hex6
    );
endinterface

// File: rtl/score_digits_gen.sv
// 3-digit BCD score counter that counts awarded points in one per clock and emits glyph codes.
// Optional high-score register and view enabled by SCORE_HISCORE_EN.
module score_digits_gen #(
    parameter int ADD_W     = 8,
    parameter int PLAYER_ID = 1,
    parameter int MAX_SCORE = 999
) (
    input logic              clk,
    input logic              resetN,
    score_digits_gen_if.slave bus
);
    localparam int PW = ADD_W + 2;
    localparam logic [3:0] MAX_D2 = 4'(MAX_SCORE / 100);
    localparam logic [3:0] MAX_D1 = 4'((MAX_SCORE / 10) % 10);
    localparam logic [3:0] MAX_D0 = 4'(MAX_SCORE % 10);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pending_q, pending_d;
    logic [3:0]    d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
    logic          sat_q, sat_d;
    logic          at_max;
    logic [PW:0]   pend_sum;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        d0_d      = d0_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        sat_d     = sat_q;
        at_max    = ({d2_q, d1_q, d0_q} == {MAX_D2, MAX_D1, MAX_D0});
        pend_sum  = {1'b0, pending_q} - (PW+1)'(1) + {{(PW+1-ADD_W){1'b0}}, bus.add_pts};

        if (bus.score_clr) begin
            state_d   = IDLE;
            pending_d = '0;
            d0_d      = '0;
            d1_d      = '0;
            d2_d      = '0;
            sat_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.add_req && bus.add_pts != '0 && !sat_q) begin
                        pending_d = {2'b00, bus.add_pts};
                        state_d   = COUNT;
                    end
                end
                COUNT: begin
                    // At the ceiling the pending increment is dropped rather than wrapping.
                    if (at_max) begin
                        sat_d     = 1'b1;
                        pending_d = '0;
                        state_d   = IDLE;
                    end else begin
                        if (d0_q == 4'd9) begin
                            d0_d = 4'd0;
                            if (d1_q == 4'd9) begin
                                d1_d = 4'd0;
                                d2_d = d2_q + 4'd1;
                            end else begin
                                d1_d = d1_q + 4'd1;
                            end
                        end else begin
                            d0_d = d0_q + 4'd1;
                        end
                        if (bus.add_req)
                            pending_d = pend_sum[PW] ? '1 : pend_sum[PW-1:0];
                        else
                            pending_d = pending_q - PW'(1);
                        if (pending_d == '0)
                            state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            pending_q <= '0;
            d0_q      <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            d0_q      <= d0_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            sat_q     <= sat_d;
        end
    end

    assign bus.busy = (state_q == COUNT);
    assign bus.sat  = sat_q;
    assign bus.hex4 = 5'd17;
    assign bus.hex6 = 5'd16;

`ifdef SCORE_HISCORE_EN
    logic [3:0] h0_q, h0_d, h1_q, h1_d, h2_q, h2_d;

    // Packed BCD compares correctly as plain binary, digit by digit.
    always_comb begin
        {h2_d, h1_d, h0_d} = {h2_q, h1_q, h0_q};
        if ({d2_q, d1_q, d0_q} > {h2_q, h1_q, h0_q})
            {h2_d, h1_d, h0_d} = {d2_q, d1_q, d0_q};
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h0_q <= '0;
            h1_q <= '0;
            h2_q <= '0;
        end else begin
            h0_q <= h0_d;
            h1_q <= h1_d;
            h2_q <= h2_d;
        end
    end

    assign bus.hex1 = {1'b0, bus.show_hi ? h0_q : d0_q};
    assign bus.hex2 = {1'b0, bus.show_hi ? h1_q : d1_q};
    assign bus.hex3 = {1'b0, bus.show_hi ? h2_q : d2_q};
    assign bus.hex5 = bus.show_hi ? 5'd0 : 5'(PLAYER_ID);
`else
    logic unused_show_hi;
    assign unused_show_hi = bus.show_hi;
    assign bus.hex1 = {1'b0, d0_q};
    assign bus.hex2 = {1'b0, d1_q};
    assign bus.hex3 = {1'b0, d2_q};
    assign bus.hex5 = 5'(PLAYER_ID);
`endif
endmodule

// File: tb/tb_score_digits_gen.sv
// Directed table-driven bench for score_digits_gen: counting, carry, back-to-back awards,
// clear, saturation, async reset and (with SCORE_HISCORE_EN) the high-score view.
module tb_score_digits_gen;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    score_digits_gen_if #(.ADD_W(8)) bus ();

    score_digits_gen #(.ADD_W(8), .PLAYER_ID(1), .MAX_SCORE(999)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic req;
        int   pts;
        logic clr;
        int   cyc;
        int   score;
        logic busy;
        logic sat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_score(input string nm, input int exp);
        int e;
        e = int'({5'(exp / 100), 5'((exp / 10) % 10), 5'(exp % 10)});
        check(nm, int'({bus.hex3, bus.hex2, bus.hex1}), e);
    endtask

    task automatic check_all(input string tag, input int score, input logic busy, input logic sat);
        check_score({tag, " score"}, score);
        check({tag, " busy"}, int'(bus.busy), int'(busy));
        check({tag, " sat"}, int'(bus.sat), int'(sat));
        check({tag, " const"}, int'({bus.hex6, bus.hex5, bus.hex4}), int'({5'd16, 5'd1, 5'd17}));
    endtask

    // Inputs held for the first edge only, then cyc-1 idle edges; sample 1 time unit after.
    task automatic apply(input logic req, input int pts, input logic clr, input int cyc);
        bus.add_req   = req;
        bus.add_pts   = 8'(pts);
        bus.score_clr = clr;
        @(posedge clk); #1;
        bus.add_req   = 1'b0;
        bus.add_pts   = 8'd0;
        bus.score_clr = 1'b0;
        for (int k = 1; k < cyc; k++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.add_req   = 1'b0;
        bus.add_pts   = 8'd0;
        bus.score_clr = 1'b0;
        bus.show_hi   = 1'b0;

        //                 req pts clr cyc score busy sat
        vecs.push_back('{1'b1,  12, 1'b0,   1,   0, 1'b1, 1'b0});
        vecs.push_back('{1'b0,   0, 1'b0,   9,   9, 1'b1, 1'b0});
        vecs.push_back('{1'b0,   0, 1'b0,   1,  10, 1'b1, 1'b0});
        vecs.push_back('{1'b0,   0, 1'b0,   1,  11, 1'b1, 1'b0});
        vecs.push_back('{1'b0,   0, 1'b0,   1,  12, 1'b0, 1'b0});
        vecs.push_back('{1'b0,   0, 1'b0,   3,  12, 1'b0, 1'b0});
        vecs.push_back('{1'b1,   0, 1'b0,   1,  12, 1'b0, 1'b0});
        vecs.push_back('{1'b1,   3, 1'b0,   1,  12, 1'b1, 1'b0});
        vecs.push_back('{1'b1,   4, 1'b0,   1,  13, 1'b1, 1'b0});
        vecs.push_back('{1'b0,   0, 1'b0,   5,  18, 1'b1, 1'b0});
        vecs.push_back('{1'b1,   2, 1'b0,   1,  19, 1'b1, 1'b0});
        vecs.push_back('{1'b0,   0, 1'b0,   1,  20, 1'b1, 1'b0});
        vecs.push_back('{1'b0,   0, 1'b0,   1,  21, 1'b0, 1'b0});
        vecs.push_back('{1'b1,  60, 1'b0,   1,  21, 1'b1, 1'b0});
        vecs.push_back('{1'b0,   0, 1'b0,  10,  31, 1'b1, 1'b0});
        vecs.push_back('{1'b1,   7, 1'b1,   1,   0, 1'b0, 1'b0});
        vecs.push_back('{1'b0,   0, 1'b0,   3,   0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 255, 1'b0,   1,   0, 1'b1, 1'b0});
        vecs.push_back('{1'b0,   0, 1'b0, 255, 255, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 255, 1'b0, 256, 510, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 255, 1'b0, 256, 765, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 225, 1'b0, 226, 990, 1'b0, 1'b0});
        vecs.push_back('{1'b1,  25, 1'b0,   1, 990, 1'b1, 1'b0});
        vecs.push_back('{1'b0,   0, 1'b0,   9, 999, 1'b1, 1'b0});
        vecs.push_back('{1'b0,   0, 1'b0,   1, 999, 1'b0, 1'b1});
        vecs.push_back('{1'b1,   5, 1'b0,   3, 999, 1'b0, 1'b1});
        vecs.push_back('{1'b0,   0, 1'b1,   1,   0, 1'b0, 1'b0});

        // Reset state, both while held and after release.
        repeat (2) @(posedge clk);
        #1;
        check_all("in_reset", 0, 1'b0, 1'b0);
        resetN = 1'b1;
        @(posedge clk); #1;
        check_all("post_reset", 0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].req, vecs[i].pts, vecs[i].clr, vecs[i].cyc);
            check_all($sformatf("vec%0d", i), vecs[i].score, vecs[i].busy, vecs[i].sat);
        end

        // Async reset mid-count must clear without waiting for an edge.
        apply(1'b1, 20, 1'b0, 5);
        check_all("pre_async", 4, 1'b1, 1'b0);
        resetN = 1'b0;
        #2;
        check_all("async_rst", 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        resetN = 1'b1;
        apply(1'b0, 0, 1'b0, 3);
        check_all("after_async", 0, 1'b0, 1'b0);

`ifdef SCORE_HISCORE_EN
        apply(1'b1, 40, 1'b0, 41);
        check_all("hi_reach40", 40, 1'b0, 1'b0);
        apply(1'b0, 0, 1'b1, 1);
        check_all("hi_clr", 0, 1'b0, 1'b0);
        apply(1'b1, 15, 1'b0, 16);
        check_all("hi_reach15", 15, 1'b0, 1'b0);
        bus.show_hi = 1'b1;
        #1;
        check_score("hi_view", 40);
        check("hi_view hex5", int'(bus.hex5), 0);
        bus.show_hi = 1'b0;
        #1;
        check_all("live_view", 15, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/score_digits_gen.md
Name: score_digits_gen

Overview:
- Upstream stage of the six-digit 7-segment score display.
- Holds the player's score as a 3-digit BCD counter, accepts point-award requests from game logic, and counts them in one unit per clock.
- Presents six 5-bit glyph codes (hex6..hex1) to the display stage.
- Glyph codes: 0-9 are digits, 16 = 'P', 17 = '-'.

Parameters:
- ADD_W, 8, width of add_pts request value.
- PLAYER_ID, 1, digit (0-9) shown on hex5.
- MAX_SCORE, 999, saturation ceiling (BCD 9/9/9; must be ≤999).

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- add_req  in  1  one-cycle pulse: award add_pts points
- add_pts  in  ADD_W  points to award (binary)
- score_clr  in  1  synchronous score clear (new game)
- show_hi  in  1  select high-score view (only with SCORE_HISCORE_EN)
- busy  out  1  points pending count-in
- sat  out  1  score reached MAX_SCORE (sticky until clear)
- hex1  out  5  units digit code
- hex2  out  5  tens digit code
- hex3  out  5  hundreds digit code
- hex4  out  5  constant 17 ('-')
- hex5  out  5  PLAYER_ID
- hex6  out  5  constant 16 ('P')

Behaviour:
- Reset (resetN=0, async): score digits=0/0/0, pending=0, state=IDLE, busy=0, sat=0. hex1..3=0, hex4=17, hex5=PLAYER_ID, hex6=16 (constants independent of reset).
- Registers:
  - pending: width ADD_W+2, binary, saturates at all-ones (never wraps).
  - d0/d1/d2: BCD digits.
- FSM states: IDLE, COUNT.
- IDLE:
  - add_req=1 with add_pts≠0 → pending=add_pts, go COUNT.
  - add_req=1 with add_pts=0 → ignored.
- COUNT, each clock:
  - Score increments by 1 (BCD ripple: d0 9→0 carries into d1, d1 9→0 carries into d2).
  - pending decrements by 1.
  - If add_req=1 in the same cycle, pending_next = pending−1+add_pts (saturating).
  - Leave for IDLE when pending_next==0.
- Latency: request accepted at edge t; N points are visible on hex1..3 after edge t+N. busy falls on the same edge as the final increment.
- busy = (state==COUNT); registered, no combinational path from add_req.
- Saturation:
  - An increment that would exceed MAX_SCORE is suppressed.
  - Score holds at MAX_SCORE, sat←1, pending←0, go IDLE.
  - In IDLE with sat=1, add_req is ignored.
- score_clr: highest priority below reset. Next edge: score=0, pending=0, sat=0, state=IDLE (aborts COUNT). An add_req in the same cycle is dropped.
- hex1..3 are combinational from the digit registers, zero-extended to 5 bits. Codes 10-15 never appear.
- show_hi without the macro: ignored.

Optional Feature:
- Macro: SCORE_HISCORE_EN.
- Defined:
  - Adds 3-digit BCD register hi (reset 0/0/0). score_clr does not clear it.
  - Every clock where score > hi (BCD magnitude compare), hi←score.
  - While show_hi=1: hex1..3 show hi, hex5 shows 0.
  - busy, sat and counting are unaffected.
- Undefined: no hi register, show_hi unused, hex1..3 always show live score.

Test Plan:
- Reset release, no stimulus → hex6..hex1 = 16,PLAYER_ID(1),17,0,0,0; busy=0; sat=0.
- add_req add_pts=12 at edge t → busy=1 from t; score 000→012 after edge t+12; busy=0 after t+12; BCD carry 009→010 seen at t+10.
- Score 990, add_req add_pts=25 → counts to 999, sat=1, busy drops next edge, score holds 999; further add_req 5 → no change.
- In COUNT with pending=3, add_req add_pts=4 → total 7 more increments with no gap; back-to-back request on final count cycle extends COUNT without returning to IDLE.
- Mid-COUNT score_clr (pending=50) → next edge score 000, busy=0, sat=0; simultaneous add_req dropped. resetN low mid-COUNT → immediate async clear.
- [SCORE_HISCORE_EN] reach 040, clear, reach 015, show_hi=1 → hex3..1 = 0,4,0, hex5=0; show_hi=0 → 0,1,5.
